// File: rtl/mpc_h_v_seq.sv
// Fill/drain sequencer that owns the single port of the h-vector RAM.
// Define MPC_H_V_SEQ_CHECKSUM_EN to add a running sum of filled words on `checksum`.
module mpc_h_v_seq #(
  parameter int DataWidth    = 32,
  parameter int AddressWidth = 5,
  parameter int AddressRange = 24
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load_start,
  input  logic                    read_start,
  input  logic [DataWidth-1:0]    in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [DataWidth-1:0]    out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [AddressWidth-1:0] ram_address0,
  output logic                    ram_ce0,
  output logic                    ram_we0,
  output logic [DataWidth-1:0]    ram_d0,
  input  logic [DataWidth-1:0]    ram_q0,
`ifdef MPC_H_V_SEQ_CHECKSUM_EN
  output logic [DataWidth-1:0]    checksum,
`endif
  output logic                    busy,
  output logic                    done
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StFill  = 2'd1;
  localparam logic [1:0] StDrain = 2'd2;
  localparam logic [AddressWidth-1:0] LastAddr = AddressWidth'(AddressRange - 1);

  logic [1:0]              state_q, state_d;
  logic [AddressWidth-1:0] wr_ptr_q, wr_ptr_d;
  logic [AddressWidth-1:0] rd_ptr_q, rd_ptr_d;
  logic [AddressWidth-1:0] pop_cnt_q, pop_cnt_d;
  logic                    rd_all_q, rd_all_d;
  logic                    arm_q, arm_d;
  logic                    inflight_q, inflight_d;
  logic                    done_q, done_d;
  logic [1:0]              occ_q, occ_d;
  logic [DataWidth-1:0]    buf0_q, buf0_d, buf1_q, buf1_d;
  logic                    fill_hs, pop, issue;
  logic [2:0]              pending;
`ifdef MPC_H_V_SEQ_CHECKSUM_EN
  logic [DataWidth-1:0]    csum_q, csum_d;
  assign checksum = csum_q;
`endif

  assign in_ready  = (state_q == StFill) & ~reset;
  assign fill_hs   = in_ready & in_valid;
  assign out_valid = (occ_q != 2'd0);
  assign out_data  = buf0_q;
  assign pop       = out_valid & out_ready;

  // Words already held or arriving next edge, net of this cycle's pop; keeps the 2-entry buffer from overflowing.
  assign pending = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
  // The first drain cycle is a setup cycle with no read, so the first word appears three edges after the start.
  assign issue   = (state_q == StDrain) & ~reset & ~arm_q & ~rd_all_q & (pending < 3'd2);

  assign ram_ce0      = fill_hs | issue;
  assign ram_we0      = fill_hs;
  assign ram_address0 = fill_hs ? wr_ptr_q : (issue ? rd_ptr_q : '0);
  assign ram_d0       = fill_hs ? in_data : '0;
  assign busy         = (state_q != StIdle);
  assign done         = done_q;

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    pop_cnt_d  = pop_cnt_q;
    rd_all_d   = rd_all_q;
    arm_d      = 1'b0;
    done_d     = 1'b0;
    inflight_d = issue;
`ifdef MPC_H_V_SEQ_CHECKSUM_EN
    csum_d     = csum_q;
`endif

    case (state_q)
      StIdle: begin
        if (load_start) begin
          state_d  = StFill;
          wr_ptr_d = '0;
`ifdef MPC_H_V_SEQ_CHECKSUM_EN
          csum_d   = '0;
`endif
        end else if (read_start) begin
          state_d   = StDrain;
          arm_d     = 1'b1;
          rd_ptr_d  = '0;
          rd_all_d  = 1'b0;
          pop_cnt_d = '0;
        end
      end
      StFill: begin
        if (fill_hs) begin
`ifdef MPC_H_V_SEQ_CHECKSUM_EN
          csum_d = csum_q + in_data;
`endif
          if (wr_ptr_q == LastAddr) begin
            wr_ptr_d = '0;
            state_d  = StIdle;
            done_d   = 1'b1;
          end else begin
            wr_ptr_d = wr_ptr_q + AddressWidth'(1);
          end
        end
      end
      StDrain: begin
        if (issue) begin
          if (rd_ptr_q == LastAddr) begin
            rd_ptr_d = '0;
            rd_all_d = 1'b1;
          end else begin
            rd_ptr_d = rd_ptr_q + AddressWidth'(1);
          end
        end
        if (pop) begin
          if (pop_cnt_q == LastAddr) begin
            pop_cnt_d = '0;
            state_d   = StIdle;
            done_d    = 1'b1;
          end else begin
            pop_cnt_d = pop_cnt_q + AddressWidth'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Two-entry FIFO kept head-aligned in buf0 so out_data needs no mux.
  always_comb begin
    occ_d  = occ_q;
    buf0_d = buf0_q;
    buf1_d = buf1_q;
    if (pop) begin
      buf0_d = buf1_q;
      occ_d  = occ_q - 2'd1;
    end
    if (inflight_q) begin
      if (occ_d == 2'd0) buf0_d = ram_q0;
      else               buf1_d = ram_q0;
      occ_d = occ_d + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      pop_cnt_q  <= '0;
      rd_all_q   <= 1'b0;
      arm_q      <= 1'b0;
      inflight_q <= 1'b0;
      done_q     <= 1'b0;
      occ_q      <= 2'd0;
      buf0_q     <= '0;
      buf1_q     <= '0;
`ifdef MPC_H_V_SEQ_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      pop_cnt_q  <= pop_cnt_d;
      rd_all_q   <= rd_all_d;
      arm_q      <= arm_d;
      inflight_q <= inflight_d;
      done_q     <= done_d;
      occ_q      <= occ_d;
      buf0_q     <= buf0_d;
      buf1_q     <= buf1_d;
`ifdef MPC_H_V_SEQ_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

endmodule

// File: tb/tb_mpc_h_v_seq.sv
// Directed bench for mpc_h_v_seq: per-cycle vector table for fill/drain plus
// hand-written sequences for gaps, backpressure, reset abort and start priority.
module tb_mpc_h_v_seq;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int AR = 24;

  logic          clk = 1'b0;
  logic          reset, load_start, read_start;
  logic [DW-1:0] in_data;
  logic          in_valid, in_ready;
  logic [DW-1:0] out_data;
  logic          out_valid, out_ready;
  logic [AW-1:0] ram_address0;
  logic          ram_ce0, ram_we0;
  logic [DW-1:0] ram_d0, ram_q0;
  logic          busy, done;
`ifdef MPC_H_V_SEQ_CHECKSUM_EN
  logic [DW-1:0] checksum;
`endif

  mpc_h_v_seq #(.DataWidth(DW), .AddressWidth(AW), .AddressRange(AR)) dut (
    .clk(clk), .reset(reset), .load_start(load_start), .read_start(read_start),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .ram_address0(ram_address0), .ram_ce0(ram_ce0), .ram_we0(ram_we0),
    .ram_d0(ram_d0), .ram_q0(ram_q0),
`ifdef MPC_H_V_SEQ_CHECKSUM_EN
    .checksum(checksum),
`endif
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Single-port read-first RAM model, 1-cycle read latency.
  logic [DW-1:0] mem [32];
  always @(posedge clk) begin
    if (ram_ce0) begin
      ram_q0 <= mem[ram_address0];
      if (ram_we0) mem[ram_address0] <= ram_d0;
    end
  end

  typedef struct {
    logic          ls, rs, iv, ordy;
    logic [DW-1:0] id;
    logic          e_irdy, e_ce, e_we, e_ov, e_busy, e_done;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_d0, e_od;
  } vec_t;

  vec_t tbl [64];
  int   ntbl = 0;
  int   nvec = 0;
  int   nmis = 0;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end else begin
      $display("ok   %s: %0h", name, got);
    end
  endtask

  task automatic add(input logic ls, rs, iv, ordy, input logic [DW-1:0] id,
                     input logic irdy, ce, we, input logic [AW-1:0] addr, input logic [DW-1:0] d0,
                     input logic ov, input logic [DW-1:0] od, input logic bsy, dn);
    vec_t v;
    v.ls = ls; v.rs = rs; v.iv = iv; v.ordy = ordy; v.id = id;
    v.e_irdy = irdy; v.e_ce = ce; v.e_we = we; v.e_addr = addr; v.e_d0 = d0;
    v.e_ov = ov; v.e_od = od; v.e_busy = bsy; v.e_done = dn;
    tbl[ntbl] = v;
    ntbl++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int nwr, ndone, npop, niss, maxout;
    logic [127:0] act, exp;

    reset = 1'b1; load_start = 1'b0; read_start = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

    // Continuous fill of 0x1000+k, then drain with out_ready held high.
    add(1, 0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0, 0, 0);
    for (int k = 0; k < AR; k++)
      add(0, 0, 1, 0, 32'h1000 + k,  1, 1, 1, AW'(k), 32'h1000 + k,  0, 0, 1, 0);
    add(0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0, 0, 1);
    add(0, 1, 0, 1, 0,  0, 0, 0, 0, 0,  0, 0, 0, 0);
    for (int c = 0; c <= 26; c++)
      add(0, 0, 0, 1, 0,  0, (c >= 1 && c <= 24), 0, AW'(c - 1), 0,
          (c >= 3 && c <= 26), 32'h1000 + c - 3, 1, 0);
    add(0, 0, 0, 1, 0,  0, 0, 0, 0, 0,  0, 0, 0, 1);

    tick();
    @(negedge clk);
    chk("reset_state", {in_ready, out_valid, ram_ce0, ram_we0, busy, done, ram_address0, ram_d0, out_data}, '0);
    tick();
    reset = 1'b0;

    for (int i = 0; i < ntbl; i++) begin
      load_start = tbl[i].ls; read_start = tbl[i].rs; in_valid = tbl[i].iv;
      in_data = tbl[i].id; out_ready = tbl[i].ordy;
      @(negedge clk);
      act = {in_ready, ram_ce0, ram_we0, tbl[i].e_ce ? ram_address0 : 5'd0, tbl[i].e_ce ? ram_d0 : 32'd0,
             out_valid, tbl[i].e_ov ? out_data : 32'd0, busy, done};
      exp = {tbl[i].e_irdy, tbl[i].e_ce, tbl[i].e_we, tbl[i].e_ce ? tbl[i].e_addr : 5'd0,
             tbl[i].e_ce ? tbl[i].e_d0 : 32'd0, tbl[i].e_ov, tbl[i].e_ov ? tbl[i].e_od : 32'd0,
             tbl[i].e_busy, tbl[i].e_done};
      chk($sformatf("vec%0d", i), act, exp);
      tick();
    end
    load_start = 1'b0; read_start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;

    // Fill with in_valid toggling every other cycle.
    load_start = 1'b1; tick(); load_start = 1'b0;
    nwr = 0; ndone = 0;
    for (int k = 0; k < 200 && ndone == 0; k++) begin
      in_valid = (k % 2 == 0);
      in_data  = 32'h2000 + nwr;
      @(negedge clk);
      if (ram_ce0) begin
        chk($sformatf("gap_wr%0d", nwr), {ram_we0, in_valid, ram_address0, ram_d0},
            {1'b1, 1'b1, AW'(nwr), 32'h2000 + nwr});
        nwr++;
      end
      if (done) ndone++;
      tick();
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("gap_after", {done, ram_ce0, busy}, 3'b000);
    tick();
    chk("gap_writes", nwr, AR);
    chk("gap_done", ndone, 1);

    // Drain with out_ready pattern 1,0,0,...
    read_start = 1'b1; tick(); read_start = 1'b0;
    npop = 0; niss = 0; maxout = 0; ndone = 0;
    for (int c = 0; c < 300 && ndone == 0; c++) begin
      out_ready = (c % 3 == 0);
      @(negedge clk);
      if (ram_ce0 && !ram_we0) niss++;
      if (out_valid && out_ready) begin
        chk($sformatf("bp_pop%0d", npop), out_data, 32'h2000 + npop);
        npop++;
      end
      if (niss - npop > maxout) maxout = niss - npop;
      if (done) ndone++;
      tick();
    end
    out_ready = 1'b0;
    chk("bp_pops", npop, AR);
    chk("bp_issues", niss, AR);
    chk("bp_done", ndone, 1);
    nvec++;
    if (maxout > 2) begin
      nmis++;
      $display("FAIL bp_outstanding: got %0d expected at most 2", maxout);
    end else begin
      $display("ok   bp_outstanding: %0d", maxout);
    end

    // Reset after 10 words of a fill; the 11th word must not be written.
    load_start = 1'b1; tick(); load_start = 1'b0;
    for (int k = 0; k < 10; k++) begin
      in_valid = 1'b1; in_data = 32'h3000 + k;
      tick();
    end
    in_data = 32'h300A; reset = 1'b1;
    @(negedge clk);
    chk("rst_cycle_ce", {ram_ce0, ram_we0, in_ready}, 3'b000);
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_after", {in_ready, busy, ram_ce0, done}, 4'b0000);
    tick();
    in_valid = 1'b0;
    chk("rst_mem9", mem[9], 32'h3009);
    chk("rst_mem10", mem[10], 32'h200A);

    // Both starts together: fill wins.
    load_start = 1'b1; read_start = 1'b1; tick(); load_start = 1'b0; read_start = 1'b0;
    for (int k = 0; k < AR; k++) begin
      in_valid = 1'b1; in_data = 32'h4000 + k;
      @(negedge clk);
      if (k == 0) chk("both_is_fill", {in_ready, busy, ram_ce0, ram_we0}, 4'hF);
      tick();
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("fill2_done", {done, busy, in_ready}, 3'b100);
    tick();

    read_start = 1'b1; out_ready = 1'b1; tick(); read_start = 1'b0;
    npop = 0; ndone = 0;
    for (int c = 0; c < 60 && ndone == 0; c++) begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        chk($sformatf("d2_pop%0d", npop), out_data, 32'h4000 + npop);
        npop++;
      end
      if (done) ndone++;
      tick();
    end
    out_ready = 1'b0;
    chk("d2_pops", npop, AR);
    chk("d2_done", ndone, 1);

`ifdef MPC_H_V_SEQ_CHECKSUM_EN
    load_start = 1'b1; tick(); load_start = 1'b0;
    for (int k = 0; k < AR; k++) begin
      in_valid = 1'b1;
      in_data  = (k == 0) ? 32'hFFFF_FFFF : ((k == 1) ? 32'h1 : 32'h0);
      @(negedge clk);
      if (k == 0) chk("csum_cleared", checksum, 32'h0);
      if (k == 1) chk("csum_first", checksum, 32'hFFFF_FFFF);
      tick();
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("csum_done", {done, checksum}, {1'b1, 32'h0});
    tick();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/mpc_h_v_seq.md
Name: mpc_h_v_seq

Overview:
- Sequencer directly upstream of the 24-entry h-vector RAM in the MPC controller.
- Fill mode: accepts a valid/ready stream of AddressRange h-vector words from the h computation and writes them to RAM addresses 0..AddressRange-1.
- Drain mode: reads the RAM back in address order and presents the words on a valid/ready stream to the QP solver datapath.
- Owns the RAM's single port. It hides the RAM's 1-cycle, read-first latency behind a 2-entry output buffer.

Parameters:
- DataWidth, 32, word width of the stream and the RAM data.
- AddressWidth, 5, RAM address width.
- AddressRange, 24, number of words per vector. Must be ≥2 and ≤2^AddressWidth.

Ports:
- clk  in  1  single clock; all logic samples on the rising edge.
- reset  in  1  synchronous, active-high reset.
- load_start  in  1  request a fill; sampled only in IDLE.
- read_start  in  1  request a drain; sampled only in IDLE.
- in_data  in  DataWidth  fill stream data.
- in_valid  in  1  fill stream valid.
- in_ready  out  1  fill stream ready.
- out_data  out  DataWidth  drain stream data.
- out_valid  out  1  drain stream valid.
- out_ready  in  1  drain stream ready.
- ram_address0  out  AddressWidth  RAM address.
- ram_ce0  out  1  RAM chip enable.
- ram_we0  out  1  RAM write enable.
- ram_d0  out  DataWidth  RAM write data.
- ram_q0  in  DataWidth  RAM read data, valid the cycle after ce0 with we0=0.
- busy  out  1  high in FILL or DRAIN.
- done  out  1  one-cycle pulse when a fill or drain completes.

Behaviour:
- Reset values: state=IDLE, pointers=0, buffer empty. in_ready, out_valid, ram_ce0, ram_we0, busy and done are all 0. ram_address0, ram_d0 and out_data are all 0.
- Reset has priority over every other input. Reset mid-FILL or mid-DRAIN aborts with no further RAM access. Data in flight is discarded and partial RAM contents are left as-is.
- States: IDLE, FILL, DRAIN.
  - IDLE→FILL on load_start.
  - IDLE→DRAIN on read_start.
  - If both are asserted together, FILL wins and read_start is ignored.
  - Starts asserted outside IDLE are ignored (not queued).
- FILL:
  - in_ready=1.
  - A handshake is in_valid&in_ready. On a handshake, the same cycle drives ram_ce0=1, ram_we0=1, ram_address0=wr_ptr and ram_d0=in_data (combinational pass-through), then increments wr_ptr.
  - Without a handshake, ram_ce0=0.
  - On the handshake at wr_ptr=AddressRange-1: wr_ptr←0 and state→IDLE. done=1 in the following cycle; in_ready=0 from that cycle.
  - in_valid gaps are allowed with no limit.
- DRAIN:
  - ram_we0=0. A read is issued (ram_ce0=1, ram_address0=rd_ptr, rd_ptr++) when rd_ptr<AddressRange and (buffer occupancy + reads in flight − this cycle's pop) < 2.
  - ram_q0 is captured into the buffer on the edge after the cycle following the issue.
  - out_valid = buffer non-empty. out_data = buffer head. A pop is out_valid&out_ready.
  - The first out_valid is asserted in the cycle after the third rising edge following the edge that samples read_start.
  - With out_ready held high, throughput is 1 word/cycle.
  - Backpressure never drops or duplicates words.
  - Completion: after the pop of word AddressRange-1 → IDLE, with done=1 in the next cycle.
- busy=1 exactly while state≠IDLE. done is never asserted while busy=1.
- Pointer arithmetic is unsigned AddressWidth bits. Pointers never wrap past AddressRange-1 within an operation.

Optional Feature:
- Macro: MPC_H_V_SEQ_CHECKSUM_EN.
- Enabled:
  - Adds output port checksum (DataWidth). It accumulates the modulo-2^DataWidth sum of every word accepted during FILL.
  - Cleared to 0 on reset and on entry to FILL. Held stable outside FILL and valid when done pulses.
  - Drain is unaffected.
- Disabled: the port and accumulator are absent. All other behaviour is identical.

Test Plan:
- Fill, continuous: load_start, then in_valid held high with in_data=0x1000+i for i=0..23 → 24 single-cycle writes with we0=1 at addresses 0..23 and d0 matching; done pulses once in the cycle after the 24th handshake; busy falls in the same cycle.
- Fill with gaps: in_valid toggled every other cycle → same 24 writes, in order, no extra ce0 cycles.
- Drain after fill: read_start with out_ready=1 → out_valid first asserted in the cycle after the third edge; then 24 consecutive words 0x1000..0x1017 in order; done pulses once.
- Drain with backpressure: out_ready pattern 1,0,0,1,… → all 24 words delivered exactly once, in order; at most 2 reads outstanding beyond what was popped.
- Reset mid-fill after word 10 → next cycle in_ready=0, busy=0, ram_ce0=0. A subsequent full fill then drain returns the new data.
- load_start and read_start high together in IDLE → FILL entered. With MPC_H_V_SEQ_CHECKSUM_EN and words 0xFFFFFFFF,1,0×22, checksum=0x00000000 at done.
